i2c_master: RTL

Bus-initiator counterpart to the I2C memory controller. Accepts single-byte write or read requests from user logic and generates START, a 7-bit address plus R/W frame, one data byte, the ACK/NACK slots and STOP on an open-drain SCL/SDA pair. It sits between the user/test logic and the I2C lines that feed the memory-side controller; completion and read data are returned to the user.

---
 rtl/i2c_master.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C bus initiator (START, addr+R/W, data, ACK slots, STOP)
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   req, rw, addr, wdata request strobe (sampled in IDLE), direction, 7-bit target, write byte
//   busy, done           transaction in progress / one-cycle completion pulse
//   rdata, ack_err       last successfully read byte / last transaction saw a NACK
//   scl, sda_oe, sda_i   SCL level, SDA pull-low enable, sampled SDA line
// Configuration macro: I2C_MASTER_ACK_CHECK_EN (abort to STOP on a NACKed ACK slot).
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK, STOP
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          done_q, done_d;
`ifdef I2C_MASTER_ACK_CHECK_EN
    logic          ack_err_q, ack_err_d;
    logic          nack_q, nack_d;
`endif

    logic q_last, bit_end, sample;

    assign q_last  = (qcnt_q == QW'(CLK_DIV - 1));
    assign bit_end = q_last && (phase_q == 2'd3);
    assign sample  = q_last && (phase_q == 2'd2);   // last cycle of Q2

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign rdata = rdata_q;
`ifdef I2C_MASTER_ACK_CHECK_EN
    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            wdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            rdata_q   <= 8'h00;
            done_q    <= 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
            ack_err_q <= 1'b0;
            nack_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
`ifdef I2C_MASTER_ACK_CHECK_EN
            ack_err_q <= ack_err_d;
            nack_q    <= nack_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
`ifdef I2C_MASTER_ACK_CHECK_EN
        ack_err_d = ack_err_q;
        nack_d    = nack_q;
`endif
        scl       = 1'b1;
        sda_oe    = 1'b0;

        // Quarter/phase counters free-run for the whole transaction.
        if (state_q != IDLE) begin
            qcnt_d = q_last ? '0 : qcnt_q + QW'(1);
            if (q_last) phase_d = phase_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = START;
                    tx_d      = {addr, rw};
                    rw_d      = rw;
                    wdata_d   = wdata;
                    qcnt_d    = '0;
                    phase_d   = 2'd0;
                    bit_d     = 3'd0;
`ifdef I2C_MASTER_ACK_CHECK_EN
                    ack_err_d = 1'b0;
`endif
                end
            end
            START: begin
                sda_oe = phase_q[1];
                if (bit_end) state_d = ADDR;
            end
            ADDR, WDATA: begin
                // Bit held for the whole period, so SDA only moves at Q0.
                scl    = phase_q[1];
                sda_oe = ~tx_q[7];
                if (bit_end) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ADDR_ACK : WDATA_ACK;
                end
            end
            ADDR_ACK: begin
                scl = phase_q[1];
`ifdef I2C_MASTER_ACK_CHECK_EN
                if (sample) nack_d = sda_i;
                if (bit_end) begin
                    if (nack_q) begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end else begin
                        state_d = rw_q ? RDATA : WDATA;
                        tx_d    = wdata_q;
                    end
                end
`else
                if (bit_end) begin
                    state_d = rw_q ? RDATA : WDATA;
                    tx_d    = wdata_q;
                end
`endif
            end
            WDATA_ACK: begin
                scl = phase_q[1];
`ifdef I2C_MASTER_ACK_CHECK_EN
                if (sample) nack_d = sda_i;
                if (bit_end && nack_q) ack_err_d = 1'b1;
`endif
                if (bit_end) state_d = STOP;
            end
            RDATA: begin
                scl = phase_q[1];
                if (sample) rx_d = {rx_q[6:0], sda_i};
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RDATA_NACK;
                end
            end
            RDATA_NACK: begin
                scl = phase_q[1];
                if (bit_end) begin
                    rdata_d = rx_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                scl    = phase_q[1];
                sda_oe = (phase_q != 2'd3);
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
